main_memory: RTL
================

Name: main_memory

Overview:
- Word-addressed 64-bit main memory. It is the responder on the l1_to_mem interface that the L1 cache drives as initiator.
- Accepts one read or write request per cycle on en/we and returns read data after a fixed, parameterised latency. There is no backpressure.
- Sits at the top level beside central_processing_unit and is the backing store for all instruction and data traffic.

Parameters:
- DEPTH, 65536: number of 64-bit words; must be a power of two, minimum 2.
- READ_LATENCY, 1: cycles from read request to rd_data update; legal range 1..4. The L1 is built against the value 1.
- ADDR_W, 61: width of the l1_to_mem__addr word address.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- l1_to_mem__addr  input  61  word address (byte address >> 3)
- l1_to_mem__wr_data  input  64  write data
- l1_to_mem__rd_data  output  64  read data
- l1_to_mem__en  input  1  request strobe, one request per asserted cycle
- l1_to_mem__we  input  1  1 = write, 0 = read; qualified by en
- mem__rd_valid  output  1  pulses with every rd_data update
- mem__oob_err  output  1  one-cycle pulse on an out-of-range access

Behaviour:
- Reset:
  - Asynchronous active-high.
  - On assertion: rd_data = 64'h0, rd_valid = 0, oob_err = 0, all read-pipeline stages invalid with zero data.
  - Array contents are not reset and are retained across reset.
- Request decode, sampled at posedge clk:
  - en=1, we=1: write wr_data to array[addr].
  - en=1, we=0: read.
  - en=0: idle; we and addr are ignored.
- Range check:
  - Address is in range iff addr < DEPTH, i.e. bits [ADDR_W-1:log2(DEPTH)] are all zero.
  - Index is addr[log2(DEPTH)-1:0].
  - Out-of-range write: array untouched.
  - Out-of-range read: returns 64'h0 with normal latency and normal rd_valid.
  - Either case pulses oob_err in the cycle after the request.
- Read pipeline:
  - A read issued at edge N is captured from the array at edge N.
  - The data travels READ_LATENCY-1 further register stages and is applied to rd_data, with rd_valid=1, at edge N+READ_LATENCY-1.
  - With READ_LATENCY=1, data is visible in the cycle after the request cycle. This matches an L1 that asserts en in one state and samples rd_data in the next.
- Hold: rd_data holds its last value when no read retires. rd_valid is 0 in those cycles.
- Back-to-back requests: full throughput. A request every cycle yields one retirement every cycle, in order.
- Read-after-write:
  - Write at edge N, then a read of the same address at edge N+1 returns the new data.
  - A read issued before a write to the same address returns the old data.
- Reset mid-operation: all in-flight reads are discarded and none retire after reset release. Writes completed before reset persist.
- No X propagation: X on addr or wr_data while en=0 must not corrupt state.

Optional Feature:
- Macro: MAIN_MEMORY_STATS_EN.
- When defined, the block adds three outputs:
  - mem__rd_count [31:0]: counts accepted reads.
  - mem__wr_count [31:0]: counts accepted in-range writes.
  - mem__oob_count [15:0]: counts out-of-range accesses.
- Counter rules:
  - All three counters clear on rst.
  - Each increments in the cycle after the triggering request.
  - rd_count and wr_count wrap at 2^32.
  - oob_count saturates at 16'hFFFF.
- When not defined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Basic write then read, DEPTH=65536, READ_LATENCY=1:
  - Stimulus: write 64'hDEADBEEF_CAFEF00D to addr 0x10 at cycle 0; read addr 0x10 at cycle 1.
  - Required: rd_data equals the written value and rd_valid=1 in cycle 2.
- Back-to-back streaming reads, READ_LATENCY=3:
  - Stimulus: write addr i = i*3 for i=0..7; then read i=0..7 on consecutive cycles.
  - Required: rd_valid high for 8 consecutive cycles, data 0,3,6,...,21 in order, first retirement 3 cycles after the first read.
- Out-of-range access:
  - Stimulus: read addr 0x1_0000 (DEPTH=65536); write 64'h1 to addr 0x1_0000.
  - Required: the read returns 0 with rd_valid=1 and an oob_err pulse; the write pulses oob_err; array[0] is unchanged.
- Read-around-write ordering:
  - Stimulus: array[5]=64'hA. Read 5, write 64'hB to 5, read 5 on consecutive cycles.
  - Required: returns 64'hA then 64'hB; rd_data holds 64'hB afterwards with rd_valid=0.
- Reset mid-flight:
  - Stimulus: READ_LATENCY=4, issue 2 reads, assert rst asynchronously between edges.
  - Required: rd_data=0 and rd_valid=0 immediately; no retirement after release; previously written data is still readable.
- With MAIN_MEMORY_STATS_EN defined:
  - Stimulus: 3 in-range writes, 5 reads, 2 out-of-range writes.
  - Required: wr_count=3, rd_count=5, oob_count=2; all three are 0 after rst.

Source files
------------

// File: rtl/main_memory.sv
// Word-addressed 64-bit backing store with a fixed-latency read pipeline and out-of-range detection.
// Define MAIN_MEMORY_STATS_EN to add read/write/out-of-range access counters.
module main_memory #(
    parameter int DEPTH        = 65536,
    parameter int READ_LATENCY = 1,
    parameter int ADDR_W       = 61
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] l1_to_mem__addr,
    input  logic [63:0]       l1_to_mem__wr_data,
    output logic [63:0]       l1_to_mem__rd_data,
    input  logic              l1_to_mem__en,
    input  logic              l1_to_mem__we,
    output logic              mem__rd_valid,
    output logic              mem__oob_err
`ifdef MAIN_MEMORY_STATS_EN
    ,
    output logic [31:0]       mem__rd_count,
    output logic [31:0]       mem__wr_count,
    output logic [15:0]       mem__oob_count
`endif
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [63:0]             mem_array [DEPTH];
    logic [IDX_W-1:0]        idx;
    logic                    in_range;
    logic                    rd_req;
    logic                    wr_req;
    logic [63:0]             rd_word;
    logic [READ_LATENCY-1:0] pipe_v;
    logic [63:0]             pipe_d [READ_LATENCY];

    assign idx      = l1_to_mem__addr[IDX_W-1:0];
    assign in_range = ((l1_to_mem__addr >> IDX_W) == '0);
    assign rd_req   = l1_to_mem__en & ~l1_to_mem__we;
    assign wr_req   = l1_to_mem__en & l1_to_mem__we;
    assign rd_word  = in_range ? mem_array[idx] : 64'h0;

    // Array contents are deliberately outside reset so they survive it.
    always_ff @(posedge clk) begin
        if (wr_req && in_range) begin
            mem_array[idx] <= l1_to_mem__wr_data;
        end
    end

    // Stage 0 captures the array on the request edge; every stage only loads
    // when its input is valid, so the last stage holds rd_data between retirements.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_v <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_d[i] <= 64'h0;
            end
        end else begin
            pipe_v[0] <= rd_req;
            if (rd_req) begin
                pipe_d[0] <= rd_word;
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                if (pipe_v[i-1]) begin
                    pipe_d[i] <= pipe_d[i-1];
                end
            end
        end
    end

    assign l1_to_mem__rd_data = pipe_d[READ_LATENCY-1];
    assign mem__rd_valid      = pipe_v[READ_LATENCY-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem__oob_err <= 1'b0;
        end else begin
            mem__oob_err <= l1_to_mem__en & ~in_range;
        end
    end

`ifdef MAIN_MEMORY_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem__rd_count  <= 32'h0;
            mem__wr_count  <= 32'h0;
            mem__oob_count <= 16'h0;
        end else begin
            if (rd_req) begin
                mem__rd_count <= mem__rd_count + 32'h1;
            end
            if (wr_req && in_range) begin
                mem__wr_count <= mem__wr_count + 32'h1;
            end
            // Out-of-range count saturates rather than wrapping.
            if (l1_to_mem__en && !in_range && (mem__oob_count != 16'hFFFF)) begin
                mem__oob_count <= mem__oob_count + 16'h1;
            end
        end
    end
`endif

endmodule
